soc_mem_ctrl: RTL and testbench

//  Parametrised memory/MMIO subsystem for the rv32i SoC: one request/response port with backpressure
//  and a configurable number of wait states. Holds ROM and RAM storage and decodes a fixed MMIO page.
//  A HALT register replaces the simulation-only brk path with a synthesizable halt flag and exit code.

---
 rtl/soc_pkg.sv | 30 +++
 rtl/soc_sram.sv | 24 ++
 rtl/soc_mem_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_soc_mem_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_pkg.sv
// Address-map defaults, MMIO register offsets and shared types for the SoC memory/MMIO subsystem.
package soc_pkg;

  localparam logic [31:0] ROM_BASE_DEF  = 32'h0000_0000;
  localparam logic [31:0] RAM_BASE_DEF  = 32'h1000_0000;
  localparam logic [31:0] MMIO_BASE_DEF = 32'hF000_0000;

  localparam logic [11:0] MMIO_HALT    = 12'h000;
  localparam logic [11:0] MMIO_CYCLE   = 12'h004;
  localparam logic [11:0] MMIO_CONSOLE = 12'h008;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;

  // Source of rsp_rdata while in RESP; NONE drives zero.
  typedef enum logic [1:0] {SEL_NONE, SEL_ROM, SEL_RAM, SEL_MMIO} rsp_sel_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } mem_req_t;

  function automatic logic in_region(input logic [31:0] addr, input logic [31:0] base,
                                     input logic [31:0] bytes);
    logic [31:0] off;
    off = addr - base;
    return off < bytes;
  endfunction

endpackage

// File: rtl/soc_sram.sv
// Single-port synchronous word array with 4-lane byte write; array 'mem' is loadable by hierarchy.
module soc_sram #(
  parameter int WORDS = 4096,
  parameter int AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++)
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/soc_mem_ctrl.sv
// Memory/MMIO subsystem: ROM, RAM, MMIO page (HALT, CYCLE), one req/rsp port with wait states.
// Optional console register at MMIO +0x008 enabled by defining SOC_MEM_CONSOLE_EN.
module soc_mem_ctrl
  import soc_pkg::*;
#(
  parameter int          ROM_WORDS   = 4096,
  parameter int          RAM_WORDS   = 4096,
  parameter logic [31:0] ROM_BASE    = ROM_BASE_DEF,
  parameter logic [31:0] RAM_BASE    = RAM_BASE_DEF,
  parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEF,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        halt,
  output logic [7:0]  exit_code
`ifdef SOC_MEM_CONSOLE_EN
  ,
  output logic        con_valid,
  output logic [7:0]  con_data
`endif
);

  localparam int          ROM_AW    = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1;
  localparam int          RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [31:0] ROM_BYTES = 32'(ROM_WORDS * 4);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  mem_state_t  state, state_nxt;
  mem_req_t    req_q;
  logic [3:0]  wcnt;
  logic [31:0] cyc_q;
  rsp_sel_t    sel_q;
  logic        err_q;
  logic [31:0] mmio_q;
  logic        commit;

  logic [31:0] rom_off, ram_off;
  logic [31:0] rom_dout, ram_dout;
  logic        is_wr;
  logic        d_err, rom_en, ram_en, halt_wr;
  rsp_sel_t    d_sel;
  logic [3:0]  ram_we;
  logic [31:0] d_mmio;
`ifdef SOC_MEM_CONSOLE_EN
  logic        con_wr;
`endif

  assign req_ready = (state == IDLE) && !halt;
  assign rsp_valid = (state == RESP);
  assign rsp_err   = err_q;
  // The access happens on the last WAIT edge only, so a reset in WAIT never commits.
  assign commit    = (state == WAIT) && (wcnt == 4'd0);
  assign is_wr     = |req_q.wstrb;
  assign rom_off   = req_q.addr - ROM_BASE;
  assign ram_off   = req_q.addr - RAM_BASE;

  // Address decode of the latched request, first match wins.
  always_comb begin
    d_err   = 1'b0;
    d_sel   = SEL_NONE;
    rom_en  = 1'b0;
    ram_en  = 1'b0;
    ram_we  = 4'b0000;
    halt_wr = 1'b0;
    d_mmio  = 32'h0;
`ifdef SOC_MEM_CONSOLE_EN
    con_wr  = 1'b0;
`endif
    if (req_q.addr[1:0] != 2'b00) begin
      d_err = 1'b1;
    end else if (in_region(req_q.addr, ROM_BASE, ROM_BYTES)) begin
      if (is_wr) d_err = 1'b1;
      else begin
        rom_en = 1'b1;
        d_sel  = SEL_ROM;
      end
    end else if (in_region(req_q.addr, RAM_BASE, RAM_BYTES)) begin
      ram_en = 1'b1;
      if (is_wr) ram_we = req_q.wstrb;
      else       d_sel  = SEL_RAM;
    end else if (req_q.addr[31:12] == MMIO_BASE[31:12]) begin
      unique case (req_q.addr[11:0])
        MMIO_HALT: begin
          if (is_wr) halt_wr = 1'b1;
          else begin
            d_sel  = SEL_MMIO;
            d_mmio = {23'b0, halt, exit_code};
          end
        end
        MMIO_CYCLE: begin
          if (is_wr) d_err = 1'b1;
          else begin
            d_sel  = SEL_MMIO;
            d_mmio = cyc_q;
          end
        end
`ifdef SOC_MEM_CONSOLE_EN
        MMIO_CONSOLE: begin
          if (is_wr) con_wr = 1'b1;
          else       d_sel  = SEL_MMIO;
        end
`endif
        default: d_err = 1'b1;
      endcase
    end else begin
      d_err = 1'b1;
    end
  end

  soc_sram #(.WORDS(ROM_WORDS)) u_rom (
    .clk   (clk),
    .en    (commit && rom_en),
    .we    (4'b0000),
    .addr  (rom_off[ROM_AW+1:2]),
    .wdata (32'h0),
    .rdata (rom_dout)
  );

  soc_sram #(.WORDS(RAM_WORDS)) u_ram (
    .clk   (clk),
    .en    (commit && ram_en),
    .we    (ram_we),
    .addr  (ram_off[RAM_AW+1:2]),
    .wdata (req_q.wdata),
    .rdata (ram_dout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid && req_ready) state_nxt = WAIT;
      WAIT:    if (wcnt == 4'd0)           state_nxt = RESP;
      RESP:    if (rsp_ready)              state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q     <= '0;
      wcnt      <= 4'd0;
      cyc_q     <= 32'h0;
      sel_q     <= SEL_NONE;
      err_q     <= 1'b0;
      mmio_q    <= 32'h0;
      halt      <= 1'b0;
      exit_code <= 8'h00;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_q <= '{addr: req_addr, wstrb: req_wstrb, wdata: req_wdata};
            wcnt  <= 4'(WAIT_STATES);
          end
        end
        WAIT: begin
          if (wcnt != 4'd0) begin
            wcnt <= wcnt - 4'd1;
          end else begin
            sel_q  <= d_sel;
            err_q  <= d_err;
            mmio_q <= d_mmio;
            if (halt_wr) begin
              halt      <= 1'b1;
              exit_code <= req_q.wdata[7:0];
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            sel_q  <= SEL_NONE;
            err_q  <= 1'b0;
            mmio_q <= 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SOC_MEM_CONSOLE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      con_valid <= 1'b0;
      con_data  <= 8'h00;
    end else begin
      con_valid <= commit && con_wr;
      if (commit && con_wr) con_data <= req_q.wdata[7:0];
    end
  end
`endif

  // Read-data sources are all registered and only move on the commit edge.
  always_comb begin
    rsp_rdata = 32'h0;
    unique case (sel_q)
      SEL_ROM:  rsp_rdata = rom_dout;
      SEL_RAM:  rsp_rdata = ram_dout;
      SEL_MMIO: rsp_rdata = mmio_q;
      default:  rsp_rdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_soc_mem_ctrl.sv
// Randomized scoreboard bench for soc_mem_ctrl against an address-map reference model.
module tb_soc_mem_ctrl;

  localparam int          WS        = 3;
  localparam int          NW        = 64;
  localparam logic [31:0] ROM_B     = 32'h0000_0000;
  localparam logic [31:0] RAM_B     = 32'h1000_0000;
  localparam logic [31:0] MMIO_B    = 32'hF000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_wstrb = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        halt;
  logic [7:0]  exit_code;

  soc_mem_ctrl #(
    .ROM_WORDS(NW), .RAM_WORDS(NW), .ROM_BASE(ROM_B), .RAM_BASE(RAM_B),
    .MMIO_BASE(MMIO_B), .WAIT_STATES(WS)
  ) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .halt(halt), .exit_code(exit_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          edge_due;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  int          edges = 0;
  int unsigned cycles_since_rst = 0;
  int          hold = 0;
  bit          seen = 0;
  logic [31:0] rom_m [NW];
  logic [31:0] ram_m [NW];
  logic        halt_m = 1'b0;
  logic [7:0]  exit_m = 8'h00;

  always @(posedge clk) edges <= edges + 1;

  // Clock edges since reset was last released: what CYCLE must report.
  always @(posedge clk or posedge rst)
    if (rst) cycles_since_rst <= 0;
    else     cycles_since_rst <= cycles_since_rst + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: decides outcome from the address map and updates model state.
  task automatic model(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       input int unsigned cyc_at_commit, output exp_t e);
    bit wr;
    longint off;
    wr      = (s != 4'b0);
    e.rdata = 32'h0;
    e.err   = 1'b0;
    e.edge_due = 0;
    if (a % 4 != 0) e.err = 1'b1;
    else if (a >= ROM_B && longint'(a) < longint'(ROM_B) + NW * 4) begin
      if (wr) e.err = 1'b1;
      else    e.rdata = rom_m[(a - ROM_B) / 4];
    end else if (a >= RAM_B && longint'(a) < longint'(RAM_B) + NW * 4) begin
      off = (a - RAM_B) / 4;
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) ram_m[off][8*b +: 8] = d[8*b +: 8];
      end else e.rdata = ram_m[off];
    end else if (a >= MMIO_B && longint'(a) < longint'(MMIO_B) + 4096) begin
      off = a - MMIO_B;
      if (off == 0) begin
        if (wr) begin
          halt_m = 1'b1;
          exit_m = d[7:0];
        end else e.rdata = {23'b0, halt_m, exit_m};
      end else if (off == 4 && !wr) e.rdata = cyc_at_commit;
      else e.err = 1'b1;
    end else e.err = 1'b1;
  endtask

  // abort=1: the request will be killed by reset, so the model must not see it.
  task automatic issue(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       input bit abort);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!req_ready) begin
      n++;
      if (n > 300) begin
        total++; bad++;
        $display("FAIL req_ready_timeout: got 0 expected 1 at %0t", $time);
        return;
      end
      @(negedge clk);
    end
    req_valid = 1'b1;
    req_addr  = a;
    req_wstrb = s;
    req_wdata = d;
    if (!abort) begin
      model(a, s, d, cycles_since_rst + 1 + WS, e);
      e.edge_due = edges + 2 + WS;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wstrb = 4'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0) begin
      n++;
      if (n > 500) begin
        total++; bad++;
        $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
        sbq.delete();
        return;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    sbq.delete();
    repeat (2) @(negedge clk);
    halt_m = 1'b0;
    exit_m = 8'h00;
    rst = 1'b0;
  endtask

  // Monitor: checks the head of the scoreboard while a response is presented, pops on consume.
  always @(negedge clk) begin
    bit r;
    if (rst) seen = 0;
    else if (rsp_valid) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0 at %0t", $time);
      end else begin
        if (!seen) begin
          chk("latency", edges, sbq[0].edge_due);
          seen = 1;
        end
        chk("rdata", rsp_rdata, sbq[0].rdata);
        chk("err", {31'b0, rsp_err}, {31'b0, sbq[0].err});
        chk("req_ready_busy", {31'b0, req_ready}, 32'h0);
      end
    end
    r = (hold > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
    if (hold > 0 && rsp_valid) hold--;
    rsp_ready = r;
    if (!rst && rsp_valid && r && sbq.size() > 0) begin
      void'(sbq.pop_front());
      seen = 0;
    end
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  s;
    int          k;
    for (int i = 0; i < NW; i++) begin
      rom_m[i] = $urandom;
      ram_m[i] = $urandom;
      u_dut.u_rom.mem[i] = rom_m[i];
      u_dut.u_ram.mem[i] = ram_m[i];
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", {31'b0, rsp_err}, 32'h0);
    chk("rst_halt", {31'b0, halt}, 32'h0);
    chk("rst_exit", {24'b0, exit_code}, 32'h0);

    issue(RAM_B + 4, 4'hF, 32'hDEADBEEF, 0);
    issue(RAM_B + 4, 4'h0, 32'h0, 0);
    issue(RAM_B + 12, 4'hF, 32'h0, 0);
    issue(RAM_B + 12, 4'b0101, 32'h11223344, 0);
    issue(RAM_B + 12, 4'h0, 32'h0, 0);
    issue(32'h2000_0000, 4'h0, 32'h0, 0);
    issue(ROM_B, 4'hF, 32'hCAFEF00D, 0);
    issue(ROM_B, 4'h0, 32'h0, 0);
    issue(RAM_B + 2, 4'h0, 32'h0, 0);
    issue(ROM_B + NW * 4, 4'h0, 32'h0, 0);
    issue(RAM_B + NW * 4, 4'hF, 32'h1, 0);
    issue(MMIO_B + 4, 4'hF, 32'h1, 0);
    issue(MMIO_B + 8, 4'h0, 32'h0, 0);
    drain();

    hold = 5;
    issue(RAM_B + 4, 4'h0, 32'h0, 0);
    drain();

    for (int i = 0; i < 250; i++) begin
      k = $urandom_range(0, 9);
      s = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
      case (k)
        0, 1:    a = ROM_B + 4 * $urandom_range(0, NW - 1);
        2, 3, 4: a = RAM_B + 4 * $urandom_range(0, NW - 1);
        5:       a = RAM_B + $urandom_range(0, NW * 4 + 16);
        6:       a = MMIO_B + 4 * $urandom_range(1, 5);
        7:       a = MMIO_B;
        8:       a = $urandom;
        default: a = ROM_B + NW * 4 + 4 * $urandom_range(0, 7);
      endcase
      if (a == MMIO_B) s = 4'h0;
      issue(a, s, $urandom, 0);
    end
    drain();

    issue(MMIO_B, 4'hF, 32'h0000_002A, 0);
    drain();
    repeat (3) begin
      @(negedge clk);
      chk("halt_set", {31'b0, halt}, 32'h1);
      chk("exit_code", {24'b0, exit_code}, 32'h2A);
      chk("halt_req_ready", {31'b0, req_ready}, 32'h0);
    end
    do_reset();
    @(negedge clk);
    chk("halt_cleared", {31'b0, halt}, 32'h0);
    chk("halt_rst_req_ready", {31'b0, req_ready}, 32'h1);

    issue(RAM_B + 8, 4'hF, 32'h5555_AAAA, 1);
    @(negedge clk);
    do_reset();
    issue(RAM_B + 8, 4'h0, 32'h0, 0);
    issue(MMIO_B + 4, 4'h0, 32'h0, 0);
    issue(MMIO_B, 4'h0, 32'h0, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
